// File: rtl/verify_scheduler.sv
// rtl/verify_scheduler.sv - two-requester frame arbiter pacing chars into a sequence checker
module verify_scheduler #(
    parameter int GAP     = 10,
    parameter int TIMEOUT = 255,
    parameter int MAX_LEN = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req0_char,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [7:0] req1_char,
    input  logic       req1_valid,
    output logic       req1_ready,
    output logic [7:0] chk_char,
    output logic       chk_valid,
    input  logic       chk_seq_valid,
    input  logic       chk_strobe,
    output logic       res_valid,
    output logic       res_owner,
    output logic       res_ok,
    output logic       res_err,
    output logic       busy
);
    localparam int GW = $clog2(GAP + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_FWD, S_GAP, S_WAIT, S_DONE} state_t;

    state_t        state, state_nxt;
    logic          ready_en;
    logic          owner, last_owner, ovf, closing;
    logic [1:0]    drain;
    logic [5:0]    body_cnt;
    logic [GW-1:0] gap_cnt;
    logic [TW-1:0] wait_cnt;

    logic          z0, z1, open0, open1, own_valid;
    logic [7:0]    own_char, fwd_data;
    logic          do_grant, grant_id, fwd_load, fwd_close, fwd_ovf, body_inc;
    logic [1:0]    drain_clr;
    logic          res_load, res_ok_nxt, res_err_nxt;

    // A requester that overflowed must have its trailing 0x00 swallowed, not treated as an open.
    assign z0        = req0_valid && (req0_char == 8'h00);
    assign z1        = req1_valid && (req1_char == 8'h00);
    assign open0     = z0 && !drain[0];
    assign open1     = z1 && !drain[1];
    assign own_valid = owner ? req1_valid : req0_valid;
    assign own_char  = owner ? req1_char : req0_char;
    assign busy      = (state != S_IDLE);
    assign res_valid = (state == S_DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        do_grant    = 1'b0;
        grant_id    = 1'b0;
        fwd_load    = 1'b0;
        fwd_data    = 8'h00;
        fwd_close   = 1'b0;
        fwd_ovf     = 1'b0;
        body_inc    = 1'b0;
        drain_clr   = 2'b00;
        res_load    = 1'b0;
        res_ok_nxt  = 1'b0;
        res_err_nxt = 1'b0;
        case (state)
            S_IDLE: if (ready_en) begin
                if (open0 && open1) begin
                    do_grant = 1'b1;
                    grant_id = ~last_owner;
                end else if (open0 || open1) begin
                    do_grant = 1'b1;
                    grant_id = open1;
                end
                req0_ready = !do_grant || !grant_id;
                req1_ready = !do_grant || grant_id;
                if (do_grant) begin
                    fwd_load  = 1'b1;
                    state_nxt = S_GAP;
                end else begin
                    drain_clr = {drain[1] && z1, drain[0] && z0};
                end
            end
            S_FWD: begin
                req0_ready = !owner;
                req1_ready = owner;
                if (own_valid) begin
                    fwd_load  = 1'b1;
                    state_nxt = S_GAP;
                    if (own_char == 8'h00) begin
                        fwd_close = 1'b1;
                    end else if (body_cnt == 6'(MAX_LEN)) begin
                        fwd_close = 1'b1;
                        fwd_ovf   = 1'b1;
                    end else begin
                        fwd_data = own_char;
                        body_inc = 1'b1;
                    end
                end
            end
            S_GAP: if (gap_cnt == GW'(GAP - 2)) state_nxt = closing ? S_WAIT : S_FWD;
            S_WAIT: begin
                if (chk_strobe) begin
                    res_load    = 1'b1;
                    res_ok_nxt  = chk_seq_valid && !ovf;
                    res_err_nxt = ovf;
                    state_nxt   = S_DONE;
                end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
                    res_load    = 1'b1;
                    res_err_nxt = 1'b1;
                    state_nxt   = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_en   <= 1'b0;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            ovf        <= 1'b0;
            closing    <= 1'b0;
            drain      <= 2'b00;
            body_cnt   <= 6'd0;
            gap_cnt    <= '0;
            wait_cnt   <= '0;
            chk_char   <= 8'h00;
            chk_valid  <= 1'b0;
            res_owner  <= 1'b0;
            res_ok     <= 1'b0;
            res_err    <= 1'b0;
        end else begin
            ready_en  <= 1'b1;
            chk_valid <= fwd_load;
            if (fwd_load) begin
                chk_char <= fwd_data;
                closing  <= fwd_close;
            end
            if (do_grant) begin
                owner    <= grant_id;
                body_cnt <= 6'd0;
                ovf      <= 1'b0;
            end
            if (body_inc) body_cnt <= body_cnt + 6'd1;
            if (fwd_ovf)  ovf <= 1'b1;
            drain    <= (drain & ~drain_clr) | (fwd_ovf ? (owner ? 2'b10 : 2'b01) : 2'b00);
            gap_cnt  <= (state == S_GAP) ? gap_cnt + 1'b1 : '0;
            wait_cnt <= (state == S_WAIT) ? wait_cnt + 1'b1 : '0;
            if (res_load) begin
                res_owner <= owner;
                res_ok    <= res_ok_nxt;
                res_err   <= res_err_nxt;
            end
            if (state == S_DONE) last_owner <= owner;
        end
    end
endmodule

// File: doc/verify_scheduler.md
VERIFY_SCHEDULER -- requirements
Module: verify_scheduler

Interface
REQ-001 SHALL have parameter GAP, default 10: minimum clock cycles between successive char pulses to the checker (freq/baud = 200/20).
REQ-002 SHALL have parameter TIMEOUT, default 255: cycles to wait for a checker verdict after the frame closes.
REQ-003 SHALL have parameter MAX_LEN, default 32: maximum number of non-zero body chars per frame.
REQ-004 SHALL have one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  system clock, all state updates on the rising edge.
REQ-006 rst  in  1  asynchronous active-low reset.
REQ-007 req0_char / req1_char  in  8  ASCII char from requester 0 / 1.
REQ-008 req0_valid / req1_valid  in  1  char present from requester 0 / 1.
REQ-009 req0_ready / req1_ready  out  1  char accepted this cycle when valid and ready are both high.
REQ-010 chk_char  out  8  char forwarded to the checker's ascii_char.
REQ-011 chk_valid  out  1  one-cycle char strobe to the checker's char_valid.
REQ-012 chk_seq_valid  in  1  checker verdict, sampled only when chk_strobe is high.
REQ-013 chk_strobe  in  1  checker verdict-ready pulse.
REQ-014 res_valid  out  1  one-cycle result pulse.
REQ-015 res_owner  out  1  requester that owns the result.
REQ-016 res_ok  out  1  sequence accepted.
REQ-017 res_err  out  1  frame aborted: overflow or timeout.
REQ-018 busy  out  1  a frame is granted.

Function
REQ-019 Frame format SHALL be: 0x00 (open), then 0..MAX_LEN non-zero chars, then 0x00 (close).
REQ-020 FSM states SHALL be IDLE, FWD, GAP, WAIT, DONE.
REQ-021 In IDLE, both readys SHALL be high.
REQ-022 In IDLE, an accepted non-zero char SHALL be dropped.
REQ-023 In IDLE, an accepted 0x00 SHALL grant that requester, forward the 0x00, and go to GAP.
REQ-024 Simultaneous 0x00 requests in IDLE SHALL be granted to the requester that is not last_owner (round-robin); last_owner resets to 1, so requester 0 wins the first tie.
REQ-025 On the IDLE cycle that grants a requester, the other requester's ready SHALL stay low.
REQ-026 In FWD, only the owner's ready SHALL be high; the non-owner's ready SHALL be low.
REQ-027 In FWD, an accepted char SHALL be driven on chk_char with chk_valid high for exactly the next cycle, then the FSM SHALL go to GAP.
REQ-028 GAP SHALL hold all readys low for GAP-1 cycles, so char pulses are spaced at least GAP cycles apart, then return to FWD.
REQ-029 If the char just forwarded was the closing 0x00, GAP SHALL exit to WAIT instead of FWD.
REQ-030 The body counter SHALL be 6 bits, cleared on grant, and incremented per non-zero char.
REQ-031 On the (MAX_LEN+1)th body char, the char SHALL be consumed but not forwarded, and a synthesized 0x00 SHALL be forwarded in its place.
REQ-032 After an overflow, the result SHALL be forced to res_ok=0, res_err=1; further owner chars up to and including its 0x00 SHALL be dropped in IDLE.
REQ-033 In WAIT, the first chk_strobe SHALL capture chk_seq_valid into res_ok (unless forced by REQ-032), with res_err=0, and go to DONE.
REQ-034 If no chk_strobe arrives within TIMEOUT cycles of entering WAIT, the FSM SHALL set res_ok=0, res_err=1 and go to DONE.
REQ-035 A chk_strobe arriving on the same cycle as the timeout SHALL take precedence over the timeout.
REQ-036 chk_strobe outside WAIT SHALL be ignored.
REQ-037 DONE SHALL pulse res_valid for one cycle with res_owner, update last_owner, and return to IDLE.
REQ-038 busy SHALL be high in FWD, GAP, WAIT and DONE.
REQ-039 Result latency: res_valid SHALL assert 1 cycle after the accepted chk_strobe.
REQ-040 chk_char SHALL hold its last value when chk_valid is low.

Reset
REQ-041 When rst=0, the block SHALL asynchronously enter IDLE.
REQ-042 During reset, all outputs SHALL be 0, including readys, chk_char=0x00 and res_*=0.
REQ-043 Reset SHALL clear all counters, clear the overflow flag, and set last_owner=1.
REQ-044 Readys SHALL go high on the first clock edge after rst returns to 1.
REQ-045 Reset mid-frame SHALL abandon the frame with no res_valid pulse.

Verification
REQ-046 Req0 sends 00 "(+12)" 00; checker strobes with seq_valid=1 -> exactly 7 chk_valid pulses, each at least 10 cycles apart; res_valid with owner=0, ok=1, err=0.
REQ-047 Req0 sends 00 "(+1A)" 00; checker strobes with seq_valid=0 -> res_valid with owner=0, ok=0, err=0.
REQ-048 Both requesters present 0x00 on the same cycle after reset -> requester 0 is granted and req1_ready stays low; on the next tie, requester 1 is granted.
REQ-049 Frame with 33 body chars -> 32 chars plus a synthesized 0x00 are forwarded; result ok=0, err=1.
REQ-050 Checker never strobes -> res_valid with err=1 exactly 255 cycles after WAIT entry; a strobe on the timeout cycle instead yields err=0.
REQ-051 Reset asserted in GAP mid-frame -> outputs are 0 immediately, no res_valid pulse, and the next frame is processed normally.
